// File: rtl/error_log_writer_if.sv
// Handshake bundle for error_log_writer: FIFO pop side and memory write side.
// master = log writer, slave = FIFO/memory environment.
interface error_log_writer_if;
    // FIFO side
    logic        VALID;
    logic [63:0] ECD;
    logic        ERD;
    // memory write channel
    logic        ACT;
    logic        NEXT;
    logic [31:0] ADDR;
    logic [63:0] DTO;

    modport master (
        input  VALID, ECD, NEXT,
        output ERD, ACT, ADDR, DTO
    );

    modport slave (
        output VALID, ECD, NEXT,
        input  ERD, ACT, ADDR, DTO
    );
endinterface

// File: rtl/error_log_writer.sv
// error_log_writer: pops error records, filters by code and appends them to a
// circular in-memory log (2^LOGW slots, one kept free), raising INTREQ.
// Ports: CLK/RESET (sync, active high), ENA, BASE, TAIL, MASK,
//   bus (VALID/ECD/ERD pop, ACT/NEXT/ADDR/DTO write), HEAD, COUNT, DROPCNT,
//   INTREQ/INTACK, BUSY.
module error_log_writer #(
    parameter int LOGW = 8
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            ENA,
    input  logic [31:0]     BASE,
    input  logic [LOGW-1:0] TAIL,
    input  logic [31:0]     MASK,
    error_log_writer_if.master bus,
    output logic [LOGW-1:0] HEAD,
    output logic [LOGW-1:0] COUNT,
    output logic [15:0]     DROPCNT,
    output logic            INTREQ,
    input  logic            INTACK,
    output logic            BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [63:0]     rec;
    logic [LOGW-1:0] head_inc;
    logic            masked;
    logic            full;
    logic            accept;
    logic            drop;
    logic            done;
    logic            erd;
    logic            act;
    logic [31:0]     addr;
    logic [63:0]     dto;

    assign head_inc = HEAD + LOGW'(1);
    assign masked   = MASK[rec[63:59]];
    // one slot stays empty so that HEAD==TAIL always means empty
    assign full     = (head_inc == TAIL);
    // mask is tested first so a discarded record never counts as a drop
    assign accept   = (state == CHECK) && !masked && !full;
    assign drop     = (state == CHECK) && !masked && full;
    assign done     = (state == WRITE) && bus.NEXT;

    assign bus.ERD  = erd;
    assign bus.ACT  = act;
    assign bus.ADDR = addr;
    assign bus.DTO  = dto;
    assign COUNT    = HEAD - TAIL;
    assign BUSY     = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        erd      = 1'b0;
        unique case (state)
            IDLE: begin
                if (ENA && bus.VALID) begin
                    erd      = 1'b1;
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                state_nx = accept ? WRITE : IDLE;
            end
            WRITE: begin
                if (bus.NEXT)
                    state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rec     <= '0;
            act     <= 1'b0;
            addr    <= '0;
            dto     <= '0;
            HEAD    <= '0;
            DROPCNT <= '0;
            INTREQ  <= 1'b0;
        end else begin
            if (erd)
                rec <= bus.ECD;
            if (accept) begin
                act  <= 1'b1;
                addr <= BASE + 32'({HEAD, 3'b000});
                dto  <= rec;
            end
            if (drop && (DROPCNT != 16'hFFFF))
                DROPCNT <= DROPCNT + 16'd1;
            if (done) begin
                act  <= 1'b0;
                HEAD <= head_inc;
            end
            // completion wins over a coincident acknowledge
            if (done)
                INTREQ <= 1'b1;
            else if (INTACK)
                INTREQ <= 1'b0;
        end
    end

endmodule

// File: tb/tb_error_log_writer.sv
// Self-checking bench for error_log_writer (LOGW=2): vector table plus
// directed sequences for back-pressure, interrupt, reset and enable cases.
module tb_error_log_writer;

    localparam int LOGW = 2;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            ENA;
    logic [31:0]     BASE;
    logic [LOGW-1:0] TAIL;
    logic [31:0]     MASK;
    logic [LOGW-1:0] HEAD;
    logic [LOGW-1:0] COUNT;
    logic [15:0]     DROPCNT;
    logic            INTREQ;
    logic            INTACK;
    logic            BUSY;

    error_log_writer_if bus ();

    error_log_writer #(.LOGW(LOGW)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .ENA     (ENA),
        .BASE    (BASE),
        .TAIL    (TAIL),
        .MASK    (MASK),
        .bus     (bus.master),
        .HEAD    (HEAD),
        .COUNT   (COUNT),
        .DROPCNT (DROPCNT),
        .INTREQ  (INTREQ),
        .INTACK  (INTACK),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    int pass_cnt = 0;
    int total = 0;

    int pops = 0;
    int npush = 0;
    int wr_cnt = 0;
    int act_cycles = 0;
    int stab_err = 0;
    int bad_pop = 0;
    int wcnt = 0;
    int mem_dly = 0;
    int ack_req = 0;
    int ack_done = 0;
    bit ack_with_next = 1'b0;

    logic [63:0] rec_mem [0:63];
    logic [31:0] wa [0:63];
    logic [63:0] wd [0:63];

    logic        p_act = 1'b0;
    logic        p_next = 1'b0;
    logic [31:0] p_addr = '0;
    logic [63:0] p_dto = '0;

    // FIFO model: head of the pushed records, advanced by observed pops
    always @(posedge CLK) begin
        #1;
        bus.VALID = (pops < npush);
        bus.ECD   = (pops < npush) ? rec_mem[pops] : 64'd0;
    end

    // memory model: NEXT after mem_dly cycles of ACT; INTACK pulses
    always @(negedge CLK) begin
        bus.NEXT = 1'b0;
        INTACK   = 1'b0;
        if (bus.ACT === 1'b1) begin
            if (wcnt >= mem_dly) begin
                bus.NEXT = 1'b1;
                INTACK   = ack_with_next;
            end
            wcnt++;
        end else begin
            wcnt = 0;
        end
        if (ack_done < ack_req) begin
            INTACK = 1'b1;
            ack_done++;
        end
    end

    // monitor: samples settled values just before each rising edge
    always @(negedge CLK) begin
        #3;
        if (bus.ERD === 1'b1) begin
            if (bus.VALID !== 1'b1)
                bad_pop++;
            pops++;
        end
        if (bus.ACT === 1'b1) begin
            act_cycles++;
            if (p_act && !p_next &&
                (bus.ADDR !== p_addr || bus.DTO !== p_dto))
                stab_err++;
            if (bus.NEXT === 1'b1) begin
                wa[wr_cnt] = bus.ADDR;
                wd[wr_cnt] = bus.DTO;
                wr_cnt++;
            end
        end
        p_act  = bus.ACT;
        p_next = bus.NEXT;
        p_addr = bus.ADDR;
        p_dto  = bus.DTO;
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #3;
        end
    endtask

    task automatic push(input logic [63:0] e);
        rec_mem[npush] = e;
        npush++;
    endtask

    typedef struct {
        logic [31:0]     base;
        logic [LOGW-1:0] tail;
        logic [31:0]     mask;
        logic [63:0]     ecd;
        bit              wr;
        logic [31:0]     addr;
        logic [LOGW-1:0] head;
        logic [LOGW-1:0] count;
        logic [15:0]     drop;
    } vec_t;

    vec_t tv [10];

    initial begin
        int p0;
        int w0;
        int a0;
        int t;
        string nm;

        tv[0] = '{32'h1000, 2'd0, 32'h0, 64'h0800_0012_3400_0056,
                  1'b1, 32'h1000, 2'd1, 2'd1, 16'd0};
        tv[1] = '{32'h1000, 2'd0, 32'h2, 64'h0800_0000_0000_0001,
                  1'b0, 32'h0, 2'd1, 2'd1, 16'd0};
        tv[2] = '{32'h1000, 2'd0, 32'h2, 64'h1000_0000_0000_0002,
                  1'b1, 32'h1008, 2'd2, 2'd2, 16'd0};
        tv[3] = '{32'h1000, 2'd0, 32'h0, 64'hF800_0000_0000_0003,
                  1'b1, 32'h1010, 2'd3, 2'd3, 16'd0};
        tv[4] = '{32'h1000, 2'd0, 32'h0, 64'h1800_0000_0000_0004,
                  1'b0, 32'h0, 2'd3, 2'd3, 16'd1};
        tv[5] = '{32'h1000, 2'd0, 32'h8, 64'h1800_0000_0000_0005,
                  1'b0, 32'h0, 2'd3, 2'd3, 16'd1};
        tv[6] = '{32'h1000, 2'd2, 32'h0, 64'h2000_0000_0000_0006,
                  1'b1, 32'h1018, 2'd0, 2'd2, 16'd1};
        tv[7] = '{32'hFFFF_FFF8, 2'd2, 32'h0, 64'h4000_0000_0000_0007,
                  1'b1, 32'hFFFF_FFF8, 2'd1, 2'd3, 16'd1};
        tv[8] = '{32'hFFFF_FFF8, 2'd3, 32'h0, 64'h8000_0000_0000_0008,
                  1'b1, 32'h0, 2'd2, 2'd3, 16'd1};
        tv[9] = '{32'h1000, 2'd3, 32'h0, 64'h2800_0000_0000_0009,
                  1'b0, 32'h0, 2'd2, 2'd3, 16'd2};

        RESET = 1'b1;
        ENA   = 1'b0;
        BASE  = 32'h1000;
        TAIL  = '0;
        MASK  = '0;
        cyc(2);
        RESET = 1'b0;
        ENA   = 1'b1;
        cyc(1);

        chk("rst_erd", 64'(bus.ERD), 64'd0);
        chk("rst_act", 64'(bus.ACT), 64'd0);
        chk("rst_addr", 64'(bus.ADDR), 64'd0);
        chk("rst_dto", bus.DTO, 64'd0);
        chk("rst_head", 64'(HEAD), 64'd0);
        chk("rst_count", 64'(COUNT), 64'd0);
        chk("rst_drop", 64'(DROPCNT), 64'd0);
        chk("rst_intreq", 64'(INTREQ), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);

        // single-record vectors, memory answers immediately
        for (int i = 0; i < 10; i++) begin
            BASE = tv[i].base;
            TAIL = tv[i].tail;
            MASK = tv[i].mask;
            p0 = pops;
            w0 = wr_cnt;
            a0 = act_cycles;
            push(tv[i].ecd);
            cyc(8);
            nm = $sformatf("v%0d", i);
            chk({nm, "_pops"}, 64'(pops - p0), 64'd1);
            chk({nm, "_wr"}, 64'(wr_cnt - w0), 64'(tv[i].wr));
            chk({nm, "_actcyc"}, 64'(act_cycles - a0), 64'(tv[i].wr));
            if (tv[i].wr && wr_cnt > w0) begin
                chk({nm, "_addr"}, 64'(wa[w0]), 64'(tv[i].addr));
                chk({nm, "_dto"}, wd[w0], tv[i].ecd);
            end
            chk({nm, "_head"}, 64'(HEAD), 64'(tv[i].head));
            chk({nm, "_count"}, 64'(COUNT), 64'(tv[i].count));
            chk({nm, "_drop"}, 64'(DROPCNT), 64'(tv[i].drop));
        end
        chk("tbl_intreq", 64'(INTREQ), 64'd1);

        // three back-to-back records, NEXT delayed 4 cycles each
        RESET = 1'b1;
        BASE  = 32'h1000;
        TAIL  = '0;
        MASK  = '0;
        cyc(1);
        RESET = 1'b0;
        mem_dly = 4;
        p0 = pops;
        w0 = wr_cnt;
        a0 = act_cycles;
        push(64'h0800_0000_0000_00A1);
        push(64'h1000_0000_0000_00A2);
        push(64'h1800_0000_0000_00A3);
        t = 0;
        while (wr_cnt - w0 < 3 && t < 80) begin
            cyc(1);
            t++;
        end
        chk("b2b_timeout", 64'(wr_cnt - w0), 64'd3);
        cyc(2);
        chk("b2b_pops", 64'(pops - p0), 64'd3);
        chk("b2b_actcyc", 64'(act_cycles - a0), 64'd15);
        chk("b2b_addr0", 64'(wa[w0]), 64'h1000);
        chk("b2b_addr1", 64'(wa[w0+1]), 64'h1008);
        chk("b2b_addr2", 64'(wa[w0+2]), 64'h1010);
        chk("b2b_dto2", wd[w0+2], 64'h1800_0000_0000_00A3);
        chk("b2b_head", 64'(HEAD), 64'd3);
        chk("b2b_stable", 64'(stab_err), 64'd0);

        // completion and INTACK in the same cycle: set wins
        mem_dly = 0;
        TAIL = 2'd3;
        ack_with_next = 1'b1;
        w0 = wr_cnt;
        push(64'h3000_0000_0000_00B1);
        cyc(8);
        ack_with_next = 1'b0;
        chk("ack_wr", 64'(wr_cnt - w0), 64'd1);
        chk("ack_head_wrap", 64'(HEAD), 64'd0);
        chk("ack_same_cycle", 64'(INTREQ), 64'd1);
        ack_req++;
        cyc(1);
        chk("ack_alone", 64'(INTREQ), 64'd0);
        cyc(1);
        chk("ack_stays_clear", 64'(INTREQ), 64'd0);

        // reset while a write waits for NEXT
        push(64'h3800_0000_0000_00C1);
        cyc(8);
        chk("pre_rst_head", 64'(HEAD), 64'd1);
        mem_dly = 1000;
        push(64'h4000_0000_0000_00C2);
        t = 0;
        while (bus.ACT !== 1'b1 && t < 20) begin
            cyc(1);
            t++;
        end
        chk("mid_act", 64'(bus.ACT), 64'd1);
        cyc(2);
        RESET = 1'b1;
        cyc(1);
        RESET = 1'b0;
        mem_dly = 0;
        chk("mid_rst_act", 64'(bus.ACT), 64'd0);
        chk("mid_rst_head", 64'(HEAD), 64'd0);
        chk("mid_rst_busy", 64'(BUSY), 64'd0);
        chk("mid_rst_addr", 64'(bus.ADDR), 64'd0);
        chk("mid_rst_intreq", 64'(INTREQ), 64'd0);

        // masked record after reset: popped, nothing else happens
        TAIL = '0;
        MASK = 32'h0000_0002;
        p0 = pops;
        w0 = wr_cnt;
        push(64'h0800_0000_0000_00D1);
        cyc(8);
        chk("msk_pops", 64'(pops - p0), 64'd1);
        chk("msk_wr", 64'(wr_cnt - w0), 64'd0);
        chk("msk_head", 64'(HEAD), 64'd0);
        chk("msk_drop", 64'(DROPCNT), 64'd0);
        chk("msk_intreq", 64'(INTREQ), 64'd0);

        // normal record after reset lands at slot 0
        MASK = '0;
        push(64'h4800_0000_0000_00D2);
        cyc(8);
        chk("post_wr", 64'(wr_cnt - w0), 64'd1);
        chk("post_addr", 64'(wa[w0]), 64'h1000);
        chk("post_head", 64'(HEAD), 64'd1);
        chk("post_intreq", 64'(INTREQ), 64'd1);

        // ENA low stalls popping
        ENA = 1'b0;
        p0 = pops;
        w0 = wr_cnt;
        push(64'h5000_0000_0000_00E1);
        cyc(6);
        chk("ena_nopop", 64'(pops - p0), 64'd0);
        chk("ena_busy", 64'(BUSY), 64'd0);
        ENA = 1'b1;
        cyc(8);
        chk("ena_pop", 64'(pops - p0), 64'd1);
        chk("ena_addr", 64'(wa[w0]), 64'h1008);
        chk("ena_head", 64'(HEAD), 64'd2);

        chk("no_pop_wo_valid", 64'(bad_pop), 64'd0);
        chk("act_stable_all", 64'(stab_err), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/error_log_writer.md
Name: error_log_writer

Overview:
- Downstream consumer of the error-record FIFO.
- Pops 64-bit error records over the VALID/ERD handshake.
- Filters each record by error code.
- Writes accepted records into a circular log in memory through the ACT/NEXT write channel, and raises an interrupt for the supervisor.
- Software drains the log and returns its tail pointer; the block counts records dropped because the log was full.

Parameters:
LOGW, 8, log2 of log depth in 64-bit records (log holds 2^LOGW entries, 2^LOGW-1 usable)

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
ENA  in  1  enable; 0 = no new record is popped
BASE  in  32  log base byte address, 8-byte aligned
TAIL  in  LOGW  software read pointer (record index)
MASK  in  32  per-code discard mask; bit n=1 discards code n
VALID  in  1  FIFO output holds a record
ECD  in  64  FIFO record; [63:59] error code
ERD  out  1  pop strobe to FIFO (one cycle)
ACT  out  1  memory write request
NEXT  in  1  memory accepts the current request
ADDR  out  32  write byte address
DTO  out  64  write data
HEAD  out  LOGW  write pointer (next free record index)
COUNT  out  LOGW  HEAD-TAIL modulo 2^LOGW
DROPCNT  out  16  saturating count of records lost to a full log
INTREQ  out  1  interrupt request, level
INTACK  in  1  interrupt acknowledge, one-cycle pulse
BUSY  out  1  state != IDLE

Behaviour:
- Reset (RESET=1 at a CLK edge): state IDLE; ERD=0, ACT=0, ADDR=0, DTO=0, HEAD=0, DROPCNT=0, INTREQ=0, BUSY=0.
- Reset mid-transaction abandons the pending write; no HEAD update.
- States: IDLE, CHECK, WRITE.
- IDLE:
  - If ENA & VALID: ERD=1 for this cycle, latch ECD into RecReg, go to CHECK.
  - ERD is combinational from (state==IDLE & ENA & VALID); never asserted outside IDLE. This gives at most one pop per record.
- CHECK (one cycle):
  - If MASK[RecReg[63:59]]=1: discard silently, go to IDLE.
  - Else if log full, i.e. HEAD+1 == TAIL (mod 2^LOGW): DROPCNT+=1, saturating at 16'hFFFF; go to IDLE.
  - Else: ADDR<=BASE+{HEAD,3'b000} (32-bit add, carry discarded), DTO<=RecReg, ACT<=1, go to WRITE.
  - Mask takes precedence over full: a masked record is never counted as dropped.
- WRITE:
  - ACT, ADDR and DTO are held stable until NEXT=1.
  - On the cycle NEXT=1: ACT<=0, HEAD<=HEAD+1 (wraps 2^LOGW-1 -> 0), INTREQ<=1, go to IDLE.
  - NEXT while ACT=0 is ignored.
- Throughput: minimum 3 cycles per record (IDLE pop, CHECK, WRITE with NEXT same cycle).
- The next pop can occur in the cycle after returning to IDLE.
- COUNT: combinational HEAD-TAIL modulo 2^LOGW; reflects the updated HEAD one cycle after NEXT.
- TAIL is sampled only in CHECK.
  - Software may move TAIL at any time.
  - Software moving TAIL past HEAD is a software error; the block does no checking.
- INTREQ:
  - Set on write completion; cleared by INTACK.
  - If completion and INTACK occur in the same cycle, set wins (INTREQ stays 1).
- ENA falling while in CHECK or WRITE: the current record completes, then the block stalls in IDLE.
- ECD is don't-care while VALID=0.

Test Plan:
- Reset, BASE=32'h1000, TAIL=0, MASK=0, one record ECD=64'h0800_0012_3400_0056, NEXT tied 1 -> ERD pulses once; ACT=1 for one cycle with ADDR=32'h1000 and DTO equal to the record; HEAD=1, COUNT=1, INTREQ=1.
- Three back-to-back records, NEXT delayed 4 cycles each -> ADDR/DTO stable while ACT=1; addresses 0x1000, 0x1008, 0x1010; HEAD=3; exactly three ERD pulses.
- MASK=32'h0000_0002, record with code 1 (ECD[63:59]=5'd1) -> ERD pulse, no ACT, HEAD and DROPCNT unchanged, INTREQ stays 0.
- LOGW=2, TAIL=0, five records -> first three written (HEAD=3, COUNT=3); records 4 and 5 popped, DROPCNT=2, no ACT. Then TAIL=2 and one more record -> written at ADDR=BASE+0x18, HEAD wraps to 0.
- INTREQ=1, INTACK pulsed in the same cycle as the next NEXT -> INTREQ remains 1. INTACK pulsed alone later -> INTREQ=0 the next cycle.
- RESET asserted while ACT=1 awaiting NEXT -> next cycle ACT=0, HEAD=0, state IDLE; a later VALID is popped normally.
